pm_ctrl: RTL and testbench

Measurement sequencer and reader for the phase monitor. It drives the phase monitor's `en_pm` through a reset/accumulate cycle. After the programmed accumulation window it reads the free-running `pm_out` count with a stability check, and averages 2^k measurements. The result is presented on a valid/ready interface to the JTAG/config register layer. It sits in the core clock domain beside each phase monitor instance and replaces bench-driven `en_pm` sequencing.

---
 rtl/pm_ctrl_pkg.sv | 17 +
 rtl/pm_ctrl_cnt.sv | 29 ++
 rtl/pm_ctrl.sv | 146 ++++++++++++++
 tb/tb_pm_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pm_ctrl_pkg.sv
// Shared types and constants for the phase-monitor measurement sequencer.
package pm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT,
        S_CAP1,
        S_CAP2,
        S_DONE
    } pm_state_t;

    // Extra accumulator bits so that 128 full-scale samples cannot overflow.
    localparam int PM_ACC_EXTRA = 7;
    localparam int PM_MAX_RETRY = 4;

endpackage

// File: rtl/pm_ctrl_cnt.sv
// Loadable down-counter that times the RST and WAIT phases of a measurement.
module pm_ctrl_cnt #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pm_ctrl.sv
// Sequences en_pm through reset/accumulate, captures pm_out with a stability
// check and averages 2^k measurements onto a valid/ready result port.
module pm_ctrl
    import pm_ctrl_pkg::*;
#(
    parameter int N_PM      = 20,
    parameter int N_WAIT    = 24,
    parameter int N_RST     = 8,
    parameter int MAX_RETRY = PM_MAX_RETRY
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic [N_RST-1:0]  cfg_rst_len,
    input  logic [N_WAIT-1:0] cfg_wait,
    input  logic [2:0]        cfg_avg_log2,
    output logic              en_pm,
    input  logic [N_PM-1:0]   pm_out,
    output logic              busy,
    output logic [N_PM-1:0]   result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              err_unstable
);

    localparam int ACC_W = N_PM + PM_ACC_EXTRA;
    localparam int RW    = $clog2(MAX_RETRY + 1);

    pm_state_t         state;
    logic [N_RST-1:0]  rst_len_q;
    logic [N_WAIT-1:0] wait_q;
    logic [2:0]        avg_q;
    logic [N_PM-1:0]   s0;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        meas_cnt;
    logic [RW-1:0]     retry_cnt;

    logic              match, accept, last;
    logic [ACC_W-1:0]  acc_next;
    logic [7:0]        meas_next;
    logic [N_RST-1:0]  rst_src;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [N_WAIT-1:0] cnt_val;

    // pm_out is asynchronous: s0 is the CDC endpoint, and two equal samples
    // one cycle apart stand in for a synchronizer on a quasi-static bus.
    assign match     = (pm_out == s0);
    assign accept    = (state == S_CAP2) && (match || retry_cnt == RW'(MAX_RETRY));
    assign acc_next  = acc + ACC_W'(pm_out);
    assign meas_next = meas_cnt + 8'd1;
    assign last      = (meas_next == (8'd1 << avg_q));
    assign cnt_dec   = (state == S_RST) || (state == S_WAIT);

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rst_src  = (state == S_IDLE) ? cfg_rst_len : rst_len_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        if ((state == S_IDLE && start) || (accept && !last)) begin
            cnt_load = 1'b1;
            cnt_val  = (rst_src == '0) ? '0 : N_WAIT'(rst_src - 1'b1);
        end else if (state == S_RST && cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = (wait_q == '0) ? '0 : wait_q - 1'b1;
        end
    end

    pm_ctrl_cnt #(.W(N_WAIT)) u_cnt (
        .clk      (clk),
        .rstb     (rstb),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= S_IDLE;
            rst_len_q    <= '0;
            wait_q       <= '0;
            avg_q        <= '0;
            s0           <= '0;
            acc          <= '0;
            meas_cnt     <= '0;
            retry_cnt    <= '0;
            en_pm        <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err_unstable <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    rst_len_q    <= cfg_rst_len;
                    wait_q       <= cfg_wait;
                    avg_q        <= cfg_avg_log2;
                    acc          <= '0;
                    meas_cnt     <= '0;
                    retry_cnt    <= '0;
                    err_unstable <= 1'b0;
                    busy         <= 1'b1;
                    en_pm        <= 1'b0;
                    state        <= S_RST;
                end
                S_RST: if (cnt_zero) begin
                    en_pm <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: if (cnt_zero) state <= S_CAP1;
                S_CAP1: begin
                    s0    <= pm_out;
                    state <= S_CAP2;
                end
                S_CAP2: begin
                    if (accept) begin
                        if (!match) err_unstable <= 1'b1;
                        acc       <= acc_next;
                        meas_cnt  <= meas_next;
                        retry_cnt <= '0;
                        if (last) begin
                            result       <= N_PM'(acc_next >> avg_q);
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            en_pm <= 1'b0;
                            state <= S_RST;
                        end
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= S_CAP1;
                    end
                end
                S_DONE: if (result_ready) begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    en_pm        <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pm_ctrl.sv
// Self-checking bench for pm_ctrl: vector table plus scoreboarded corner cases.
module tb_pm_ctrl;

    logic        clk;
    logic        rstb;
    logic        start;
    logic [7:0]  cfg_rst_len;
    logic [23:0] cfg_wait;
    logic [2:0]  cfg_avg_log2;
    logic        en_pm;
    logic [19:0] pm_out;
    logic        busy;
    logic [19:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        err_unstable;

    pm_ctrl #(.N_PM(20), .N_WAIT(24), .N_RST(8), .MAX_RETRY(4)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .cfg_rst_len  (cfg_rst_len),
        .cfg_wait     (cfg_wait),
        .cfg_avg_log2 (cfg_avg_log2),
        .en_pm        (en_pm),
        .pm_out       (pm_out),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .err_unstable (err_unstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst_len;
        int wt;
        int lg;
        int pm;
        int exp_res;
        int exp_lat;
    } vec_t;

    typedef struct {
        int res;
        bit err;
        int lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[5];

    int   total = 0;
    int   bad   = 0;
    int   rise_cnt = 0;
    bit   toggle_mode = 1'b0;
    bit   alt_mode = 1'b0;
    int   pm_base = 0;
    logic en_prev = 1'b0;

    localparam logic [19:0] TOG_A = 20'hAAAAA;
    localparam logic [19:0] TOG_B = 20'h55555;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // pm_out stimulus and en_pm rise counting, all on the falling edge.
    always @(negedge clk) begin
        if (en_pm === 1'b1 && en_prev === 1'b0) rise_cnt++;
        en_prev = en_pm;
        if (toggle_mode && en_pm === 1'b1)
            pm_out = (pm_out == TOG_A) ? TOG_B : TOG_A;
        else if (alt_mode)
            pm_out = (rise_cnt % 2 == 1) ? 20'd100 : 20'd200;
        else
            pm_out = 20'(pm_base);
    end

    task automatic launch(input int rl, input int wt, input int lg);
        @(negedge clk);
        cfg_rst_len  = 8'(rl);
        cfg_wait     = 24'(wt);
        cfg_avg_log2 = 3'(lg);
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_valid(input int first, input int maxc, output int lat);
        lat = -1;
        for (int n = first; n <= maxc; n++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", 64'(result_valid), 64'd0);
        check("busy_drop", 64'(busy), 64'd0);
        check("en_pm_idle", 64'(en_pm), 64'd0);
    endtask

    // Pops the scoreboard entry for the measurement that just completed.
    task automatic score(input string name, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({name, "_lat"}, 64'(lat), 64'(e.lat));
        if (e.res >= 0) check({name, "_res"}, 64'(result), 64'(e.res));
        check({name, "_err"}, 64'(err_unstable), 64'(e.err));
    endtask

    initial begin
        int lat;
        int r0;
        bit held;

        vecs[0] = '{rst_len: 0, wt: 0, lg: 0, pm: 'h0BEEF, exp_res: 'h0BEEF, exp_lat: 5};
        vecs[1] = '{rst_len: 1, wt: 2, lg: 1, pm: 777,     exp_res: 777,     exp_lat: 11};
        vecs[2] = '{rst_len: 3, wt: 0, lg: 2, pm: 'hFFFFF, exp_res: 'hFFFFF, exp_lat: 25};
        vecs[3] = '{rst_len: 2, wt: 3, lg: 3, pm: 12345,   exp_res: 12345,   exp_lat: 57};
        vecs[4] = '{rst_len: 7, wt: 1, lg: 0, pm: 0,       exp_res: 0,       exp_lat: 11};

        rstb = 1'b0;
        start = 1'b0;
        result_ready = 1'b0;
        cfg_rst_len = '0;
        cfg_wait = '0;
        cfg_avg_log2 = '0;
        pm_out = '0;
        repeat (3) @(negedge clk);
        check("rst_en_pm", 64'(en_pm), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_err", 64'(err_unstable), 64'd0);
        rstb = 1'b1;

        // Basic timing: en_pm low 1-4, high 5-14, valid at 17.
        pm_base = 'h12345;
        sb.push_back('{res: 'h12345, err: 1'b0, lat: 17});
        launch(4, 10, 0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("t1_en_pm_c%0d", k), 64'(en_pm), (k <= 4) ? 64'd0 : 64'd1);
        end
        wait_valid(15, 200, lat);
        score("t1", lat);
        handshake();

        foreach (vecs[i]) begin
            pm_base = vecs[i].pm;
            sb.push_back('{res: vecs[i].exp_res, err: 1'b0, lat: vecs[i].exp_lat});
            launch(vecs[i].rst_len, vecs[i].wt, vecs[i].lg);
            wait_valid(1, 2000, lat);
            score($sformatf("vec%0d", i), lat);
            handshake();
        end

        // Alternating 100/200 over 8 measurements averages to 150.
        alt_mode = 1'b1;
        r0 = rise_cnt;
        sb.push_back('{res: 150, err: 1'b0, lat: 81});
        launch(3, 5, 3);
        wait_valid(1, 2000, lat);
        score("alt", lat);
        check("alt_pulses", 64'(rise_cnt - r0), 64'd8);
        handshake();
        alt_mode = 1'b0;

        // Always-unstable capture: 4 retries, err set, +8 cycles, and a stalled
        // consumer with a start pulse that must be ignored.
        toggle_mode = 1'b1;
        sb.push_back('{res: -1, err: 1'b1, lat: 16});
        launch(2, 3, 0);
        wait_valid(1, 2000, lat);
        score("tog", lat);
        check("tog_res_any", 64'(result == TOG_A || result == TOG_B), 64'd1);
        r0 = int'(result);
        held = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = (k == 10);
            if (result_valid !== 1'b1 || result !== 20'(r0) || busy !== 1'b1) held = 1'b0;
        end
        start = 1'b0;
        toggle_mode = 1'b0;
        check("stall_held", 64'(held), 64'd1);
        // Handshake with a simultaneous start: only the return to IDLE happens.
        @(negedge clk);
        result_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("hs_start_ignored", 64'(busy), 64'd0);
        check("hs_en_pm", 64'(en_pm), 64'd0);
        check("hs_valid", 64'(result_valid), 64'd0);
        check("hs_err_sticky", 64'(err_unstable), 64'd1);

        // Async reset during WAIT of measurement 3 of 4.
        pm_base = 999;
        r0 = rise_cnt;
        launch(2, 6, 2);
        for (int k = 0; k < 200 && rise_cnt - r0 < 3; k++) @(negedge clk);
        check("mid_reached_m3", 64'(rise_cnt - r0), 64'd3);
        #2 rstb = 1'b0;
        #1;
        check("mid_en_pm", 64'(en_pm), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_result", 64'(result), 64'd0);
        check("mid_err", 64'(err_unstable), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        pm_base = 500;
        sb.push_back('{res: 500, err: 1'b0, lat: 41});
        launch(2, 6, 2);
        wait_valid(1, 2000, lat);
        score("fresh", lat);
        handshake();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
